sprite_render_scheduler: RTL and testbench

Shares the single VGA pixel-write port between all moving game objects: player, bullet and `N_ENEMY` enemies. Latches each object's one-cycle `move` pulse, grants one object at a time by fixed priority, erases its previously drawn square and draws it at its current position. On reset or `load_level` it first blanks the whole 160x120 screen, then draws every object. Sits between the player/bullet/enemy controllers and the VGA adapter.

---
 rtl/game_pkg.sv | 17 +
 rtl/sprite_render_scheduler_if.sv | 9 +
 rtl/sprite_scan.sv | 30 +++
 rtl/sprite_render_scheduler.sv | 140 ++++++++++++++
 tb/tb_sprite_render_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// game_pkg: screen geometry, colours, object indices and renderer states shared by the game blocks.
package game_pkg;
  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;
  localparam logic [7:0] X_MAX = 8'd159;
  localparam logic [6:0] Y_MAX = 7'd119;
  localparam logic [2:0] PLAYER_WIDTH = 3'd3;
  localparam logic [2:0] BULLET_WIDTH = 3'd1;
  localparam logic [2:0] COL_PLAYER = 3'b010;
  localparam logic [2:0] COL_BULLET = 3'b111;
  localparam logic [2:0] COL_ENEMY = 3'b100;
  localparam logic [2:0] COL_BG = 3'b000;
  localparam int OBJ_PLAYER = 0;
  localparam int OBJ_BULLET = 1;
  localparam int OBJ_ENEMY0 = 2;
  typedef enum logic [1:0] {CLEAR, IDLE, ERASE, DRAW} state_t;
endpackage

// File: rtl/sprite_render_scheduler_if.sv
// sprite_render_scheduler_if: pixel write port from the scheduler to the VGA adapter.
interface sprite_render_scheduler_if;
  logic plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  modport master(output plot, x, y, colour);
  modport slave(input plot, x, y, colour);
endinterface

// File: rtl/sprite_scan.sv
// sprite_scan: row-major dx/dy walk over a w x w square with a last-pixel flag.
module sprite_scan (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       step,
  input  logic [2:0] w_in,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);
  logic [2:0] w;
  logic row_end;
  assign row_end = dx == w - 3'd1;
  assign last = row_end && dy == w - 3'd1;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w <= '0;
      dx <= '0;
      dy <= '0;
    end else if (load) begin
      w <= w_in;
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      dx <= row_end ? '0 : dx + 3'd1;
      dy <= row_end ? dy + 3'd1 : dy;
    end
  end
endmodule

// File: rtl/sprite_render_scheduler.sv
// sprite_render_scheduler: arbitrates moving objects onto one pixel port, erasing and redrawing each sprite.
module sprite_render_scheduler import game_pkg::*; #(
  parameter int N_ENEMY = 4,
  parameter logic [2:0] PLAYER_COLOUR = COL_PLAYER,
  parameter logic [2:0] BULLET_COLOUR = COL_BULLET,
  parameter logic [2:0] ENEMY_COLOUR = COL_ENEMY,
  parameter logic [2:0] BG_COLOUR = COL_BG
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   load_level,
  input  logic                   player_move,
  input  logic                   bullet_move,
  input  logic [N_ENEMY-1:0]     enemy_move,
  input  logic [7:0]             player_x,
  input  logic [6:0]             player_y,
  input  logic [7:0]             bullet_x,
  input  logic [6:0]             bullet_y,
  input  logic [8*N_ENEMY-1:0]   enemy_x,
  input  logic [7*N_ENEMY-1:0]   enemy_y,
  input  logic [3*N_ENEMY-1:0]   enemy_w,
  output logic                   busy,
  sprite_render_scheduler_if.master pix
);
  localparam int N_OBJ = N_ENEMY + 2;
  localparam int IW = $clog2(N_OBJ);
  state_t state, state_nx;
  logic rst, any, scan_load, last, clear_last;
  logic [N_OBJ-1:0] pending, moves, gmask;
  logic [N_OBJ-1:0][7:0] obj_x, shx;
  logic [N_OBJ-1:0][6:0] obj_y, shy;
  logic [N_OBJ-1:0][2:0] obj_w, obj_c, shw;
  logic [IW-1:0] gnt, cur;
  logic [7:0] sx, cx;
  logic [6:0] sy, cy;
  logic [2:0] sw, scan_w, dx, dy;
  logic [8:0] px;
  logic [7:0] py;
  assign rst = !resetn || load_level;
  assign moves = {enemy_move, bullet_move, player_move};
  assign any = |pending;
  assign gmask = (state == IDLE && any) ? {{(N_OBJ-1){1'b0}}, 1'b1} << gnt : '0;
  assign clear_last = cx == X_MAX && cy == Y_MAX;
  // ERASE walks the last-drawn square, DRAW the one snapshotted at grant
  assign px = {1'b0, state == ERASE ? shx[cur] : sx} + {6'd0, dx};
  assign py = {1'b0, state == ERASE ? shy[cur] : sy} + {5'd0, dy};
  always_comb begin
    obj_x = '0;
    obj_y = '0;
    obj_w = '0;
    obj_c = '0;
    obj_x[OBJ_PLAYER] = player_x;
    obj_y[OBJ_PLAYER] = player_y;
    obj_w[OBJ_PLAYER] = PLAYER_WIDTH;
    obj_c[OBJ_PLAYER] = PLAYER_COLOUR;
    obj_x[OBJ_BULLET] = bullet_x;
    obj_y[OBJ_BULLET] = bullet_y;
    obj_w[OBJ_BULLET] = BULLET_WIDTH;
    obj_c[OBJ_BULLET] = BULLET_COLOUR;
    for (int i = 0; i < N_ENEMY; i++) begin
      obj_x[OBJ_ENEMY0+i] = enemy_x[8*i +: 8];
      obj_y[OBJ_ENEMY0+i] = enemy_y[7*i +: 7];
      obj_w[OBJ_ENEMY0+i] = enemy_w[3*i +: 3];
      obj_c[OBJ_ENEMY0+i] = ENEMY_COLOUR;
    end
  end
  always_comb begin
    gnt = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) if (pending[i]) gnt = IW'(i);
  end
  // empty squares are skipped outright so a service costs exactly its plot cycles
  always_comb begin
    state_nx = state;
    scan_load = 1'b0;
    scan_w = '0;
    unique case (state)
      CLEAR: state_nx = clear_last ? IDLE : CLEAR;
      IDLE: begin
        scan_load = any;
        scan_w = shw[gnt] != '0 ? shw[gnt] : obj_w[gnt];
        state_nx = !any ? IDLE : shw[gnt] != '0 ? ERASE : obj_w[gnt] != '0 ? DRAW : IDLE;
      end
      ERASE: begin
        scan_load = last && sw != '0;
        scan_w = sw;
        state_nx = !last ? ERASE : sw != '0 ? DRAW : IDLE;
      end
      DRAW: state_nx = last ? IDLE : DRAW;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? CLEAR : state_nx;
  sprite_scan scan (
    .clk(clk), .resetn(!rst), .load(scan_load), .step(state == ERASE || state == DRAW),
    .w_in(scan_w), .dx(dx), .dy(dy), .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      cx <= '0;
      cy <= '0;
      busy <= 1'b1;
      pix.plot <= 1'b0;
      pix.x <= '0;
      pix.y <= '0;
      pix.colour <= '0;
    end else begin
      busy <= state_nx != IDLE;
      pix.plot <= 1'b0;
      pending <= state == CLEAR && clear_last ? '1 : (pending & ~gmask) | moves;
      case (state)
        CLEAR: begin
          pix.plot <= 1'b1;
          pix.x <= cx;
          pix.y <= cy;
          pix.colour <= BG_COLOUR;
          cx <= cx == X_MAX ? '0 : cx + 8'd1;
          cy <= cx != X_MAX ? cy : (cy == Y_MAX ? '0 : cy + 7'd1);
          if (clear_last) shw <= '0;
        end
        IDLE: if (any) begin
          cur <= gnt;
          sx <= obj_x[gnt];
          sy <= obj_y[gnt];
          sw <= obj_w[gnt];
        end
        default: begin
          pix.plot <= px < SCREEN_W && py < SCREEN_H;
          pix.x <= px[7:0];
          pix.y <= py[6:0];
          pix.colour <= state == ERASE ? BG_COLOUR : obj_c[cur];
          if (last && (state == DRAW || sw == '0)) begin
            shx[cur] <= sx;
            shy[cur] <= sy;
            shw[cur] <= sw;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_render_scheduler.sv
// tb_sprite_render_scheduler: pixel-stream scoreboard against a screen-level model of erase/redraw servicing.
module tb_sprite_render_scheduler;
  logic clk = 1'b0, resetn = 1'b0, load_level = 1'b0, p_mv = 1'b0, b_mv = 1'b0;
  logic [3:0] e_mv = '0;
  logic [7:0] p_x, b_x;
  logic [6:0] p_y, b_y;
  logic [31:0] e_x;
  logic [27:0] e_y;
  logic [11:0] e_w;
  logic busy;
  int n_vec = 0, n_err = 0, n_got = 0, n_busy = 0;
  logic [17:0] got [65536];
  logic [17:0] exp_q [$];
  int exp_busy;
  int sh_x [6], sh_y [6], sh_w [6];
  sprite_render_scheduler_if pix();
  sprite_render_scheduler dut (
    .clk(clk), .resetn(resetn), .load_level(load_level),
    .player_move(p_mv), .bullet_move(b_mv), .enemy_move(e_mv),
    .player_x(p_x), .player_y(p_y), .bullet_x(b_x), .bullet_y(b_y),
    .enemy_x(e_x), .enemy_y(e_y), .enemy_w(e_w), .busy(busy), .pix(pix)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (pix.plot) begin
      got[n_got % 65536] <= {pix.x, pix.y, pix.colour};
      n_got <= n_got + 1;
    end
    if (busy) n_busy <= n_busy + 1;
  end
  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  function automatic logic [17:0] obj(input int i);
    if (i == 0) return {p_x, p_y, 3'd3};
    if (i == 1) return {b_x, b_y, 3'd1};
    return {e_x[8*(i-2) +: 8], e_y[7*(i-2) +: 7], e_w[3*(i-2) +: 3]};
  endfunction
  task automatic paint(input int bx, input int by, input int w, input logic [2:0] c);
    for (int j = 0; j < w; j++)
      for (int i = 0; i < w; i++)
        if (bx + i < 160 && by + j < 120) exp_q.push_back({8'(bx + i), 7'(by + j), c});
  endtask
  task automatic service(input int i);
    logic [17:0] o;
    int w;
    o = obj(i);
    w = int'(o[2:0]);
    paint(sh_x[i], sh_y[i], sh_w[i], 3'b000);
    paint(int'(o[17:10]), int'(o[9:3]), w, i == 0 ? 3'b010 : i == 1 ? 3'b111 : 3'b100);
    exp_busy += sh_w[i] * sh_w[i] + w * w;
    sh_x[i] = int'(o[17:10]);
    sh_y[i] = int'(o[9:3]);
    sh_w[i] = w;
  endtask
  task automatic model_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) exp_q.push_back({8'(x), 7'(y), 3'b000});
    exp_busy += 19200;
    for (int i = 0; i < 6; i++) sh_w[i] = 0;
    for (int i = 0; i < 6; i++) service(i);
  endtask
  task automatic begin_batch(output int g0, output int b0);
    exp_q.delete();
    exp_busy = 0;
    g0 = n_got;
    b0 = n_busy;
  endtask
  task automatic pulse(input logic [5:0] m);
    {e_mv, b_mv, p_mv} = m;
    @(posedge clk); #1;
    {e_mv, b_mv, p_mv} = '0;
  endtask
  task automatic settle(input string tag, input int g0, input int b0);
    int quiet, cyc, n, e0;
    quiet = 0;
    cyc = 0;
    while (quiet < 8 && cyc < 30000) begin
      @(negedge clk); #1;
      quiet = busy ? 0 : quiet + 1;
      cyc++;
    end
    check({tag, "_idle"}, 32'(quiet >= 8), 32'd1);
    n = n_got - g0;
    check({tag, "_nplot"}, n, exp_q.size());
    check({tag, "_busy"}, n_busy - b0, exp_busy);
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      e0 = n_err;
      check({tag, "_pix"}, 32'(got[(g0 + i) % 65536]), 32'(exp_q[i]));
      if (n_err != e0) break;
    end
  endtask
  task automatic randomize_objs();
    p_x = 8'($urandom_range(0, 170));
    p_y = 7'($urandom_range(0, 127));
    b_x = 8'($urandom_range(0, 170));
    b_y = 7'($urandom_range(0, 127));
    for (int i = 0; i < 4; i++) begin
      e_x[8*i +: 8] = 8'($urandom_range(0, 170));
      e_y[7*i +: 7] = 7'($urandom_range(0, 127));
      e_w[3*i +: 3] = 3'($urandom_range(0, 5));
    end
  endtask
  task automatic random_batch();
    int g0, b0;
    logic [5:0] m;
    @(posedge clk); #1;
    begin_batch(g0, b0);
    randomize_objs();
    m = 6'($urandom_range(1, 63));
    pulse(m);
    for (int i = 0; i < 6; i++) if (m[i]) service(i);
    settle("rand", g0, b0);
  endtask
  initial begin
    int g0, b0;
    p_x = 8'd80; p_y = 7'd115; b_x = 8'd40; b_y = 7'd100;
    e_x = {8'd100, 8'd50, 8'd30, 8'd10};
    e_y = {7'd60, 7'd40, 7'd20, 7'd10};
    e_w = {3'd4, 3'd0, 3'd2, 3'd3};
    @(posedge clk); #1;
    check("rst_plot", 32'(pix.plot), 0);
    check("rst_x", 32'(pix.x), 0);
    check("rst_y", 32'(pix.y), 0);
    check("rst_colour", 32'(pix.colour), 0);
    check("rst_busy", 32'(busy), 1);
    resetn = 1'b1;
    begin_batch(g0, b0);
    model_clear();
    settle("clear", g0, b0);
    @(posedge clk); #1;
    begin_batch(g0, b0);
    p_x = 8'd79;
    pulse(6'b000001);
    service(0);
    settle("player", g0, b0);
    @(posedge clk); #1;
    begin_batch(g0, b0);
    b_x = 8'd41;
    e_x[15:8] = 8'd31;
    pulse(6'b001010);
    service(1);
    service(3);
    settle("bullet_enemy", g0, b0);
    @(posedge clk); #1;
    begin_batch(g0, b0);
    e_x[7:0] = 8'd158;
    pulse(6'b000100);
    service(2);
    settle("edge_clip", g0, b0);
    @(posedge clk); #1;
    begin_batch(g0, b0);
    e_w[5:3] = 3'd0;
    pulse(6'b001000);
    service(3);
    settle("kill", g0, b0);
    @(posedge clk); #1;
    begin_batch(g0, b0);
    p_x = 8'd85;
    e_x[31:24] = 8'd20;
    pulse(6'b100001);
    repeat (3) @(posedge clk);
    #1;
    e_x[31:24] = 8'd60;
    e_y[27:21] = 7'd5;
    pulse(6'b100000);
    repeat (2) @(posedge clk);
    #1;
    e_x[31:24] = 8'd120;
    e_w[11:9] = 3'd2;
    pulse(6'b100000);
    service(0);
    service(5);
    settle("coalesce", g0, b0);
    for (int k = 0; k < 12; k++) random_batch();
    @(posedge clk); #1;
    p_x = 8'd70;
    p_y = 7'd50;
    pulse(6'b000001);
    repeat (12) @(posedge clk);
    #1;
    check("predraw_colour", 32'({pix.plot, pix.colour}), 32'({1'b1, 3'b010}));
    load_level = 1'b1;
    @(posedge clk); #1;
    check("load_plot", 32'(pix.plot), 0);
    check("load_busy", 32'(busy), 1);
    check("load_xyc", 32'({pix.x, pix.y, pix.colour}), 0);
    repeat (2) @(posedge clk);
    #1;
    check("load_hold", 32'({pix.plot, busy}), 32'({1'b0, 1'b1}));
    load_level = 1'b0;
    begin_batch(g0, b0);
    @(posedge clk); #1;
    check("load_first", 32'({pix.plot, pix.x, pix.y}), 32'({1'b1, 15'd0}));
    model_clear();
    settle("reload", g0, b0);
    for (int k = 0; k < 3; k++) random_batch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
